svreal_alu_pipe: RTL and testbench

Parametrised, pipelined fixed-point ALU built on svreal-format operands (signed significand plus fixed exponent per port). It is the sequential successor to the standalone combinational svreal operators. It adds opcode selection, saturation, a multiply-accumulate mode and valid/ready flow control, so a datapath can share one arithmetic unit across operations. It sits between a command source (sequencer or CPU register bank) and downstream svreal consumers.

---
 rtl/svreal_alu_pipe.sv | 145 ++++++++++++++
 tb/tb_svreal_alu_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/svreal_alu_pipe.sv
// svreal_alu_pipe: pipelined svreal fixed-point ALU with opcode select, saturation,
// multiply-accumulate and valid/ready flow control; the accumulator lives in the final stage.
module svreal_alu_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int A_EXP     = -8,
  parameter int B_WIDTH   = 17,
  parameter int B_EXP     = -9,
  parameter int O_WIDTH   = 18,
  parameter int O_EXP     = -10,
  parameter int ACC_WIDTH = 32,
  parameter int PIPE      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [O_WIDTH-1:0] out,
  output logic [3:0]         cmp,
  output logic               sat,
  output logic               ovf
);
  localparam int PE = A_EXP + B_EXP;
  localparam int LA = A_EXP > O_EXP ? A_EXP - O_EXP : 0;
  localparam int RA = O_EXP > A_EXP ? O_EXP - A_EXP : 0;
  localparam int LB = B_EXP > O_EXP ? B_EXP - O_EXP : 0;
  localparam int RB = O_EXP > B_EXP ? O_EXP - B_EXP : 0;
  localparam int LP = PE > O_EXP ? PE - O_EXP : 0;
  localparam int RP = O_EXP > PE ? O_EXP - PE : 0;
  // wide enough that no aligned operand, product or accumulator sum can wrap
  localparam int W = A_WIDTH + B_WIDTH + ACC_WIDTH + LA + LB + LP + 2;
  localparam logic signed [W-1:0] OMAX = (W'(1) << (O_WIDTH - 1)) - W'(1);
  localparam logic signed [W-1:0] AMAX = (W'(1) << (ACC_WIDTH - 1)) - W'(1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_MIN = 4'd3,
                         OP_MAX = 4'd4, OP_NEG = 4'd5, OP_MUX = 4'd6, OP_MAC = 4'd7,
                         OP_LDA = 4'd8, OP_CLR = 4'd9;

  typedef struct packed {
    logic                v;
    logic [3:0]          code;
    logic signed [W-1:0] aa;
    logic signed [W-1:0] pa;
    logic [O_WIDTH-1:0]  r;
    logic                s;
    logic [3:0]          cm;
  } rec_t;

  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] m);
    return x > m ? m : x < ~m ? ~m : x;
  endfunction

  logic signed [W-1:0] aa, bb, pa, rw, rc;
  rec_t s0, fin;
  logic [PIPE-1:0] en;
  logic en_out;
  logic signed [ACC_WIDTH-1:0] acc;

  always_comb begin
    aa = (W'(signed'(a)) <<< LA) >>> RA;
    bb = (W'(signed'(b)) <<< LB) >>> RB;
    pa = ((W'(signed'(a)) * W'(signed'(b))) <<< LP) >>> RP;
    rw = '0;
    case (op)
      OP_ADD: rw = aa + bb;
      OP_SUB: rw = aa - bb;
      OP_MUL: rw = pa;
      OP_MIN: rw = aa < bb ? aa : bb;
      OP_MAX: rw = aa > bb ? aa : bb;
      OP_NEG: rw = -aa;
      OP_MUX: rw = sel ? aa : bb;
      default: ;
    endcase
    rc = clamp(rw, OMAX);
  end

  assign s0 = '{v: in_valid, code: op, aa: aa, pa: pa, r: rc[O_WIDTH-1:0], s: rc != rw,
                cm: {aa < bb, aa <= bb, aa > bb, aa >= bb}};

  assign en_out = !out_valid || out_ready;
  assign en[PIPE-1] = en_out;
  assign in_ready = en[0];

  generate
    if (PIPE == 1) begin : g_p1
      assign fin = s0;
    end else begin : g_pn
      rec_t sr [PIPE-1];
      logic [PIPE-2:0] bub;
      // a stage may load whenever any stage from it downward holds a bubble
      for (genvar k = 0; k < PIPE - 1; k++) begin : g_s
        rec_t d;
        if (k == 0) begin : g_f
          assign d = s0;
        end else begin : g_n
          assign d = sr[k-1];
        end
        assign bub[k] = !sr[k].v;
        assign en[k] = en_out | (|bub[PIPE-2:k]);
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) sr[k] <= '0;
          else if (en[k]) sr[k] <= d;
      end
      assign fin = sr[PIPE-2];
    end
  endgenerate

  logic signed [W-1:0] nraw, nacc, ores;
  logic is_acc, is_clr, sat_n;
  logic [O_WIDTH-1:0] out_n;

  always_comb begin
    is_acc = fin.code == OP_MAC || fin.code == OP_LDA;
    is_clr = fin.code == OP_CLR;
    nraw = fin.code == OP_MAC ? W'(acc) + fin.pa : fin.aa;
    nacc = clamp(nraw, AMAX);
    ores = clamp(nacc, OMAX);
    out_n = is_acc ? ores[O_WIDTH-1:0] : is_clr ? '0 : fin.r;
    sat_n = is_acc ? (nacc != nraw || ores != nacc) : !is_clr && fin.s;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out <= '0;
      cmp <= '0;
      sat <= 1'b0;
      ovf <= 1'b0;
      acc <= '0;
    end else if (en_out) begin
      out_valid <= fin.v;
      if (fin.v) begin
        out <= out_n;
        cmp <= fin.cm;
        sat <= sat_n;
        ovf <= !is_clr && (ovf || sat_n);
        acc <= is_acc ? nacc[ACC_WIDTH-1:0] : is_clr ? '0 : acc;
      end
    end
endmodule

// File: tb/tb_svreal_alu_pipe.sv
// tb_svreal_alu_pipe: directed vectors with a queue scoreboard and an independent output monitor.
module tb_svreal_alu_pipe;
  localparam int PIPE = 2;
  localparam logic [3:0] ADD = 0, SUB = 1, MUL = 2, MIN = 3, MAX = 4, NEG = 5, MUX = 6,
                         MAC = 7, LDA = 8, CLR = 9;

  logic clk = 0, rst_n, in_valid, in_ready, sel, out_valid, out_ready, sat, ovf;
  logic [3:0] op, cmp;
  logic [15:0] a;
  logic [16:0] b;
  logic [17:0] out;

  typedef struct {
    logic [17:0] o;
    logic [3:0]  c;
    logic        s;
    logic        v;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit lat_chk = 1, saw_ir_low = 0;

  svreal_alu_pipe #(.A_WIDTH(16), .A_EXP(-8), .B_WIDTH(17), .B_EXP(-9), .O_WIDTH(18),
                    .O_EXP(-10), .ACC_WIDTH(32), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a),
    .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready), .out(out), .cmp(cmp),
    .sat(sat), .ovf(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && !in_ready) saw_ir_low = 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] o, input int av, input int bv, input logic s,
                      input int eo, input logic [3:0] ec, input logic es, input logic ev,
                      input bit push);
    int n = 0;
    in_valid = 1; op = o; a = 16'(av); b = 17'(bv); sel = s;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: op %0d not accepted in 100 cycles", o);
    end else if (push) q.push_back('{18'(eo), ec, es, ev, cyc, lat_chk});
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain_pending", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    bit prev_stall = 0;
    logic [17:0] prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no result", $signed(out));
        end else begin
          e = q.pop_front();
          chk("out", $signed(out), $signed(e.o));
          chk("cmp", cmp, e.c);
          chk("sat", sat, e.s);
          chk("ovf", ovf, e.v);
          if (e.lat) chk("latency", cyc - e.cyc, PIPE);
        end
      end
      if (rst_n && prev_stall && out_valid) chk("hold_out", $signed(out), $signed(prev_out));
      prev_stall = rst_n && out_valid && !out_ready;
      prev_out = out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; in_valid = 0; op = 0; a = 0; b = 0; sel = 0; out_ready = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_cmp", cmp, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);
    // basic ops, a=1.5 b=-0.25
    send(ADD, 384, -128, 0, 1280, 4'b0011, 0, 0, 1);
    send(SUB, 384, -128, 0, 1792, 4'b0011, 0, 0, 1);
    send(MUL, 384, -128, 0, -384, 4'b0011, 0, 0, 1);
    send(MIN, 384, -128, 0, -256, 4'b0011, 0, 0, 1);
    send(MAX, 384, -128, 0, 1536, 4'b0011, 0, 0, 1);
    send(NEG, 384, -128, 0, -1536, 4'b0011, 0, 0, 1);
    // saturation and sticky overflow
    send(ADD, 32767, 65535, 0, 131071, 4'b1100, 1, 1, 1);
    send(ADD, 384, -128, 0, 1280, 4'b0011, 0, 1, 1);
    send(CLR, 384, -128, 0, 0, 4'b0011, 0, 0, 1);
    // accumulator chain
    send(MAC, 384, -128, 0, -384, 4'b0011, 0, 0, 1);
    send(MAC, 384, -128, 0, -768, 4'b0011, 0, 0, 1);
    send(MAC, 384, -128, 0, -1152, 4'b0011, 0, 0, 1);
    send(LDA, 256, -128, 0, 1024, 4'b0011, 0, 0, 1);
    send(MAC, 384, -128, 0, 640, 4'b0011, 0, 0, 1);
    // mux, reserved opcode, accumulator untouched by reserved
    send(MUX, 384, -128, 1, 1536, 4'b0011, 0, 0, 1);
    send(MUX, 384, -128, 0, -256, 4'b0011, 0, 0, 1);
    send(4'd12, 384, -128, 0, 0, 4'b0011, 0, 0, 1);
    send(MAC, 384, -128, 0, 256, 4'b0011, 0, 0, 1);
    drain;
    // backpressure: a=-200 (-0.78125), b=300 (0.5859375)
    lat_chk = 0; saw_ir_low = 0;
    fork
      begin
        send(ADD, -200, 300, 0, -200, 4'b1100, 0, 0, 1);
        send(SUB, -200, 300, 0, -1400, 4'b1100, 0, 0, 1);
        send(MUL, -200, 300, 0, -469, 4'b1100, 0, 0, 1);
        send(MIN, -200, 300, 0, -800, 4'b1100, 0, 0, 1);
        send(MAX, -200, 300, 0, 600, 4'b1100, 0, 0, 1);
        send(NEG, -200, 300, 0, 800, 4'b1100, 0, 0, 1);
        send(MUX, -200, 300, 1, -800, 4'b1100, 0, 0, 1);
        send(MUX, -200, 300, 0, 600, 4'b1100, 0, 0, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain;
    chk("in_ready_fell", saw_ir_low, 1);
    lat_chk = 1;
    // build acc=-1152 with ovf set, then reset with commands in flight
    send(CLR, 384, -128, 0, 0, 4'b0011, 0, 0, 1);
    send(MAC, 384, -128, 0, -384, 4'b0011, 0, 0, 1);
    send(MAC, 384, -128, 0, -768, 4'b0011, 0, 0, 1);
    send(MAC, 384, -128, 0, -1152, 4'b0011, 0, 0, 1);
    send(ADD, 32767, 65535, 0, 131071, 4'b1100, 1, 1, 1);
    drain;
    out_ready = 0;
    send(MAC, 384, -128, 0, 0, 4'b0011, 0, 0, 0);
    send(MAC, 384, -128, 0, 0, 4'b0011, 0, 0, 0);
    chk("inflight_out_valid", out_valid, 1);
    chk("inflight_ovf", ovf, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_ovf", ovf, 0);
    @(posedge clk); #1 rst_n = 1;
    q.delete();
    out_ready = 1;
    send(MAC, 384, -128, 0, -384, 4'b0011, 0, 0, 1);
    drain;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
